// File: rtl/spi_slave.sv
// SPI responder oversampled in i_Clk: one byte in on MOSI and one byte out on MISO per 8 SCLK cycles.
// o_RX_DV fires SYNC_STAGES+1 cycles after the last sample edge; an empty holding register at load time sends 0x00 and flags underrun.
module spi_slave #(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Busy,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);
  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s, sclk_prev, cs_prev;
  state_t                 state, state_nxt;
  logic                   start, stop, run;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   load_en, underrun, need_load, hold_full;
  logic [7:0]             load_byte, hold_byte, tx_shift;
  logic [6:0]             rx_shift;
  logic [2:0]             bit_cnt;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // MOSI shares the SCLK synchronizer depth so the sampled bit lines up with its edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= CPOL;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    run       = 1'b0;
    case (state)
      IDLE: begin
        if (cs_prev && !cs_s) begin
          start     = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          stop      = 1'b1;
          state_nxt = IDLE;
        end else begin
          run = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lead_edge   = (sclk_s != sclk_prev) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_s != sclk_prev) && (sclk_s == CPOL);
  assign sample_edge = run && (CPHA ? trail_edge : lead_edge);
  assign shift_edge  = run && (CPHA ? lead_edge : trail_edge);
  assign load_en     = start || (shift_edge && need_load);

  // An empty holding register lets a same-cycle write bypass straight into the shifter.
  always_comb begin
    load_byte = 8'h00;
    underrun  = 1'b0;
    if (hold_full)    load_byte = hold_byte;
    else if (i_TX_DV) load_byte = i_TX_Byte;
    else              underrun  = load_en;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      hold_full     <= 1'b0;
      hold_byte     <= 8'h00;
      tx_shift      <= 8'h00;
      rx_shift      <= 7'h00;
      bit_cnt       <= 3'd7;
      need_load     <= 1'b0;
      o_SPI_MISO    <= 1'b0;
      o_RX_DV       <= 1'b0;
      o_RX_Byte     <= 8'h00;
      o_TX_Underrun <= 1'b0;
    end else begin
      o_RX_DV       <= 1'b0;
      o_TX_Underrun <= underrun;

      if (i_TX_DV && (hold_full || !load_en)) begin
        hold_byte <= i_TX_Byte;
        hold_full <= 1'b1;
      end else if (load_en) begin
        hold_full <= 1'b0;
      end

      if (start) begin
        bit_cnt   <= 3'd7;
        need_load <= 1'b0;
        if (CPHA) begin
          tx_shift <= load_byte;
        end else begin
          tx_shift   <= {load_byte[6:0], 1'b0};
          o_SPI_MISO <= load_byte[7];
        end
      end else if (stop) begin
        bit_cnt    <= 3'd7;
        need_load  <= 1'b0;
        o_SPI_MISO <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            o_RX_Byte <= {rx_shift, mosi_s};
            o_RX_DV   <= 1'b1;
            need_load <= 1'b1;
          end
        end
        // The first shift edge after a completed byte starts the next one without a gap.
        if (shift_edge) begin
          if (need_load) begin
            o_SPI_MISO <= load_byte[7];
            tx_shift   <= {load_byte[6:0], 1'b0};
            need_load  <= 1'b0;
          end else begin
            o_SPI_MISO <= tx_shift[7];
            tx_shift   <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_TX_Ready    = !hold_full;
  assign o_Busy        = (state == ACTIVE);
  assign o_SPI_MISO_En = o_Busy;

endmodule
